// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: opcode and sequencer state types shared by the VeriRISC control stage
package ctrl_sequencer_pkg;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
  typedef enum logic [2:0] {INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE} state_t;
  function automatic logic is_aluop(opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: opcode/zero inputs and control strobes of the sequencer
//   master: drives opcode, zero; observes strobes and instr_count
//   slave:  the sequencer side
interface ctrl_sequencer_if #(parameter int CNT_WIDTH = 16);
  import ctrl_sequencer_pkg::*;
  opcode_t opcode;
  logic zero;
  logic sel;
  logic rd;
  logic ld_ir;
  logic inc_pc;
  logic halt;
  logic ld_pc;
  logic data_e;
  logic ld_ac;
  logic wr;
  logic [CNT_WIDTH-1:0] instr_count;
  modport master(output opcode, zero,
                 input sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, instr_count);
  modport slave(input opcode, zero,
                output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, instr_count);
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: 8-state VeriRISC instruction sequencer with sticky halt and retired-instruction counter
//   clk_  : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : opcode/zero in; sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, instr_count out
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input logic clk_,
  input logic rst_n,
  ctrl_sequencer_if.slave bus
);
  state_t r_state;
  state_t w_next;
  logic r_halted;
  logic [CNT_WIDTH-1:0] r_count;
  logic w_hlt;
  logic w_alu;
  assign w_hlt = bus.opcode == HLT;
  assign w_alu = is_aluop(bus.opcode);
  assign bus.instr_count = r_count;
  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INST_ADDR;
      r_halted <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_halted <= r_halted | (r_state == OP_ADDR && w_hlt);
      r_count <= r_count + CNT_WIDTH'(r_state == STORE);
    end
  end
  // the state_t encoding is sequential, so +1 walks the instruction cycle
  always_comb begin
    w_next = r_state == OP_ADDR && (r_halted || w_hlt) ? OP_ADDR :
             r_state == STORE ? INST_ADDR : state_t'(r_state + 3'd1);
  end
  always_comb begin
    bus.sel = 1'b0;
    bus.rd = 1'b0;
    bus.ld_ir = 1'b0;
    bus.inc_pc = 1'b0;
    bus.halt = 1'b0;
    bus.ld_pc = 1'b0;
    bus.data_e = 1'b0;
    bus.ld_ac = 1'b0;
    bus.wr = 1'b0;
    case (r_state)
      INST_ADDR: bus.sel = 1'b1;
      INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        bus.sel = 1'b1;
        bus.rd = 1'b1;
        bus.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = !w_hlt && !r_halted;
        bus.halt = w_hlt || r_halted;
      end
      OP_FETCH: bus.rd = w_alu;
      ALU_OP: begin
        bus.rd = w_alu;
        bus.inc_pc = bus.opcode == SKZ && bus.zero;
        bus.ld_pc = bus.opcode == JMP;
        bus.data_e = bus.opcode == STO;
      end
      STORE: begin
        bus.rd = w_alu;
        bus.ld_ac = w_alu;
        bus.inc_pc = bus.opcode == JMP;
        bus.ld_pc = bus.opcode == JMP;
        bus.wr = bus.opcode == STO;
        bus.data_e = bus.opcode == STO;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench driving directed instructions into two sequencers (16- and 2-bit counters)
module tb_ctrl_sequencer;
  import ctrl_sequencer_pkg::*;
  typedef struct {
    logic [8:0] s;
    logic [15:0] c;
  } exp_t;
  localparam logic [8:0] RST = 9'b100000000;
  localparam logic [8:0] OPA = 9'b000100000;
  localparam logic [8:0] HLTV = 9'b000010000;
  localparam logic [8:0] NONE = 9'b000000000;
  logic clk_ = 1'b0;
  logic rst_n = 1'b0;
  opcode_t op = ADD;
  logic z = 1'b0;
  logic [15:0] ecnt = '0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  ctrl_sequencer_if #(.CNT_WIDTH(16)) bus();
  ctrl_sequencer_if #(.CNT_WIDTH(2)) bus2();
  assign bus.opcode = op;
  assign bus.zero = z;
  assign bus2.opcode = op;
  assign bus2.zero = z;
  ctrl_sequencer #(.CNT_WIDTH(16)) dut (.clk_(clk_), .rst_n(rst_n), .bus(bus));
  ctrl_sequencer #(.CNT_WIDTH(2)) dut2 (.clk_(clk_), .rst_n(rst_n), .bus(bus2));
  always #5 clk_ = ~clk_;
  always @(negedge clk_) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e = q.pop_front();
      got = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt, bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
      checks++;
      if (got !== e.s) begin
        errors++;
        $display("FAIL strobes t=%0t got %b want %b", $time, got, e.s);
      end
      checks++;
      if (bus.instr_count !== e.c) begin
        errors++;
        $display("FAIL instr_count t=%0t got %0d want %0d", $time, bus.instr_count, e.c);
      end
      checks++;
      if (bus2.instr_count !== e.c[1:0]) begin
        errors++;
        $display("FAIL instr_count_w2 t=%0t got %0d want %0d", $time, bus2.instr_count, e.c[1:0]);
      end
    end
  end
  task automatic cyc(input logic [8:0] s);
    q.push_back('{s, ecnt});
    @(posedge clk_);
    #1;
  endtask
  task automatic instr(input opcode_t o, input logic zz, input logic [8:0] a, b, c, d, input int n);
    logic [8:0] v[8];
    v = '{RST, 9'b110000000, 9'b111000000, 9'b111000000, a, b, c, d};
    op = o;
    z = zz;
    for (int i = 0; i < n; i++) cyc(v[i]);
    if (n == 8) ecnt++;
  endtask
  task automatic reset_pulse();
    @(negedge clk_);
    #2 rst_n = 1'b0;
    @(posedge clk_);
    #1;
    ecnt = '0;
    cyc(RST);
    rst_n = 1'b1;
  endtask
  initial begin
    @(posedge clk_);
    #1;
    cyc(RST);
    cyc(RST);
    rst_n = 1'b1;
    instr(ADD, 1'b0, OPA, 9'b010000000, 9'b010000000, 9'b010000010, 8);
    instr(STO, 1'b0, OPA, NONE, 9'b000000100, 9'b000000101, 8);
    instr(SKZ, 1'b1, OPA, NONE, 9'b000100000, NONE, 8);
    instr(SKZ, 1'b0, OPA, NONE, NONE, NONE, 8);
    instr(JMP, 1'b0, OPA, NONE, 9'b000001000, 9'b000101000, 8);
    instr(LDA, 1'b0, OPA, 9'b010000000, 9'b010000000, 9'b010000010, 6);
    q.push_back('{9'b010000000, ecnt});
    reset_pulse();
    instr(XOR, 1'b1, OPA, 9'b010000000, 9'b010000000, 9'b010000010, 8);
    instr(HLT, 1'b0, HLTV, NONE, NONE, NONE, 5);
    for (int i = 0; i < 22; i++) begin
      if (i == 11) op = ADD;
      cyc(HLTV);
    end
    reset_pulse();
    instr(AND, 1'b0, OPA, 9'b010000000, 9'b010000000, 9'b010000010, 8);
    cyc(RST);
    @(negedge clk_);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
